pulse_train_gen: RTL and testbench

- Transmit-side counterpart of the team's pulse-counting control unit.
- On a start strobe S, emits a programmed number of clean pulses on X and then asserts a one-cycle done flag G.
- Drives the X input of a pulse counter/integrator, either to stimulate it or to feed a downstream consumer.
- Built as the same T-state control FSM plus counter datapath style.

---
 rtl/pulse_train_gen_pkg.sv | 28 ++
 rtl/pulse_down_counter.sv | 39 +++
 rtl/pulse_train_gen.sv | 167 ++++++++++++++++
 tb/tb_pulse_train_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and width helpers for the pulse train generator.
package pulse_train_gen_pkg;

  // Control states: idle, pulse-high, pulse-low gap, done.
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  // Default pulse-count width and the matching remaining-pulse counter width.
  localparam int WIDTH_DEF = 4;
  localparam int CNTW_DEF  = WIDTH_DEF + 1;

  // Remaining-pulse counter is one bit wider so that N=0 (2^WIDTH) fits.
  function automatic int cnt_width(input int width);
    return width + 1;
  endfunction

  // Phase counter holds at most max(hi, lo)-1.
  function automatic int phase_width(input int hi, input int lo);
    int m;
    m = (hi > lo) ? hi : lo;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable saturating down counter with a count==1 terminal flag.
module pulse_down_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         one_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load has priority over decrement; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign one_o   = (count_q == W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: on start, emits N pulses on X, then a one-cycle G.
//
// Handshake: S is a single-cycle request accepted only in idle with A low;
// A cancels a train in progress (pulse-high or gap) without producing G.
// S, A and N are sampled on the rising clock edge; every output is a flop.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int HIGH_CYC = 1,
  parameter int LOW_CYC  = 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             S,
  input  logic             A,
  input  logic [WIDTH-1:0] N,
  output logic             X,
  output logic             G,
  output logic             busy,
  output logic [WIDTH:0]   q
);

  localparam int CNTW = cnt_width(WIDTH);
  localparam int PW   = phase_width(HIGH_CYC, LOW_CYC);

  state_e state_q;
  logic   x_q, g_q, busy_q;

  logic            rem_load, rem_dec, rem_one;
  logic [CNTW-1:0] rem_val, rem_cnt;
  logic            ph_load, ph_dec, ph_one_unused;
  logic [PW-1:0]   ph_val, ph_cnt;
  logic            ph_zero;

  assign ph_zero = (ph_cnt == '0);

  // Counter controls derived from the current state and sampled inputs.
  always_comb begin
    rem_load = 1'b0;
    rem_val  = '0;
    rem_dec  = 1'b0;
    ph_load  = 1'b0;
    ph_val   = '0;
    ph_dec   = 1'b0;
    case (state_q)
      T0: begin
        if (S && !A) begin
          rem_load = 1'b1;
          rem_val  = (N == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, N};
          ph_load  = 1'b1;
          ph_val   = PW'(HIGH_CYC - 1);
        end
      end
      T1: begin
        if (A) begin
          rem_load = 1'b1;
          ph_load  = 1'b1;
        end else if (!ph_zero) begin
          ph_dec = 1'b1;
        end else begin
          rem_dec = 1'b1;
          if (!rem_one) begin
            ph_load = 1'b1;
            ph_val  = PW'(LOW_CYC - 1);
          end
        end
      end
      T2: begin
        if (A) begin
          rem_load = 1'b1;
          ph_load  = 1'b1;
        end else if (!ph_zero) begin
          ph_dec = 1'b1;
        end else begin
          ph_load = 1'b1;
          ph_val  = PW'(HIGH_CYC - 1);
        end
      end
      default: begin
      end
    endcase
  end

  // Control FSM with registered X, G and busy.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T0;
      x_q     <= 1'b0;
      g_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        T0: begin
          g_q <= 1'b0;
          if (S && !A) begin
            x_q     <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= T1;
          end
        end
        T1: begin
          if (A) begin
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= T0;
          end else if (ph_zero) begin
            x_q <= 1'b0;
            if (rem_one) begin
              g_q     <= 1'b1;
              state_q <= T3;
            end else begin
              state_q <= T2;
            end
          end
        end
        T2: begin
          if (A) begin
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= T0;
          end else if (ph_zero) begin
            x_q     <= 1'b1;
            state_q <= T1;
          end
        end
        T3: begin
          g_q     <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= T0;
        end
        default: begin
          x_q     <= 1'b0;
          g_q     <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= T0;
        end
      endcase
    end
  end

  pulse_down_counter #(.W(CNTW)) u_rem_cnt (
    .clk_i      (CLK),
    .rst_ni     (rst_n),
    .load_i     (rem_load),
    .load_val_i (rem_val),
    .dec_i      (rem_dec),
    .count_o    (rem_cnt),
    .one_o      (rem_one)
  );

  pulse_down_counter #(.W(PW)) u_phase_cnt (
    .clk_i      (CLK),
    .rst_ni     (rst_n),
    .load_i     (ph_load),
    .load_val_i (ph_val),
    .dec_i      (ph_dec),
    .count_o    (ph_cnt),
    .one_o      (ph_one_unused)
  );

  assign X    = x_q;
  assign G    = g_q;
  assign busy = busy_q;
  assign q    = rem_cnt;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: two configurations driven by the same stimulus.
module tb_pulse_train_gen;

  localparam int W  = 4;
  localparam int HC [2] = '{1, 2};
  localparam int LC [2] = '{1, 3};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         S, A;
  logic [W-1:0] N;

  logic         x_a, g_a, busy_a;
  logic [W:0]   q_a;
  logic         x_b, g_b, busy_b;
  logic [W:0]   q_b;

  pulse_train_gen #(.WIDTH(W), .HIGH_CYC(1), .LOW_CYC(1)) dut_a (
    .CLK(clk), .rst_n(rst_n), .S(S), .A(A), .N(N),
    .X(x_a), .G(g_a), .busy(busy_a), .q(q_a)
  );

  pulse_train_gen #(.WIDTH(W), .HIGH_CYC(2), .LOW_CYC(3)) dut_b (
    .CLK(clk), .rst_n(rst_n), .S(S), .A(A), .N(N),
    .X(x_b), .G(g_b), .busy(busy_b), .q(q_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Expected pulse count of each started train on dut_a, retired on G.
  logic [7:0] exp_q[$];
  int         rises_a;
  logic       prev_xa;

  // Reference model: a train is a list of cycles indexed by k from the start.
  bit act [2];
  int mn  [2];
  int mk  [2];

  function automatic int train_len(input int n, input int h, input int l);
    return n * h + (n - 1) * l + 1;
  endfunction

  // Expected {X, G, busy, q} at offset k of an n-pulse train.
  function automatic logic [7:0] exp_out(input int n, input int h, input int l, input int k);
    int per, p, w;
    logic x;
    logic [4:0] qv;
    if (k == train_len(n, h, l) - 1) return {1'b0, 1'b1, 1'b1, 5'd0};
    per = h + l;
    p   = k / per;
    w   = k % per;
    x   = (w < h);
    qv  = x ? 5'(n - p) : 5'(n - p - 1);
    return {x, 1'b0, 1'b1, qv};
  endfunction

  task automatic model_edge(input logic s, input logic a, input logic [W-1:0] n);
    for (int i = 0; i < 2; i++) begin
      if (!act[i]) begin
        if (s && !a) begin
          act[i] = 1'b1;
          mn[i]  = (n == 0) ? (1 << W) : int'(n);
          mk[i]  = 0;
          if (i == 0) begin
            exp_q.push_back(8'(mn[i]));
            rises_a = 0;
          end
        end
      end else if (mk[i] == train_len(mn[i], HC[i], LC[i]) - 1) begin
        act[i] = 1'b0;
      end else if (a) begin
        act[i] = 1'b0;
        if (i == 0 && exp_q.size() > 0) void'(exp_q.pop_back());
      end else begin
        mk[i]++;
      end
    end
  endtask

  task automatic model_reset();
    act[0] = 1'b0;
    act[1] = 1'b0;
    exp_q.delete();
    rises_a = 0;
    prev_xa = 1'b0;
  endtask

  task automatic compare_outputs();
    logic [7:0] ea, eb;
    ea = act[0] ? exp_out(mn[0], HC[0], LC[0], mk[0]) : 8'd0;
    eb = act[1] ? exp_out(mn[1], HC[1], LC[1], mk[1]) : 8'd0;
    check_eq("a_X",    x_a,    ea[7]);
    check_eq("a_G",    g_a,    ea[6]);
    check_eq("a_busy", busy_a, ea[5]);
    check_eq("a_q",    q_a,    ea[4:0]);
    check_eq("b_X",    x_b,    eb[7]);
    check_eq("b_G",    g_b,    eb[6]);
    check_eq("b_busy", busy_b, eb[5]);
    check_eq("b_q",    q_b,    eb[4:0]);
    if (x_a && !prev_xa) rises_a++;
    prev_xa = x_a;
    if (g_a) begin
      if (exp_q.size() == 0) check_eq("a_unexpected_done", 1, 0);
      else check_eq("a_pulse_count", rises_a, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic s, input logic a, input logic [W-1:0] n);
    S = s;
    A = a;
    N = n;
    @(posedge clk);
    model_edge(s, a, n);
    #1;
    compare_outputs();
  endtask

  // Start an n-pulse train and run both configurations to idle.
  task automatic run_train(input logic [W-1:0] n, input bit mid_s);
    int ba, bb, ne;
    ne = (n == 0) ? (1 << W) : int'(n);
    step(1'b1, 1'b0, n);
    ba = busy_a ? 1 : 0;
    bb = busy_b ? 1 : 0;
    for (int c = 0; c < 300 && (busy_a || busy_b); c++) begin
      step(mid_s && busy_a && busy_b, 1'b0, W'($urandom_range(0, 15)));
      if (busy_a) ba++;
      if (busy_b) bb++;
    end
    check_eq("train_timeout", busy_a || busy_b, 0);
    check_eq("a_busy_len", ba, train_len(ne, HC[0], LC[0]));
    check_eq("b_busy_len", bb, train_len(ne, HC[1], LC[1]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    S = 1'b0;
    A = 1'b0;
    N = '0;
    model_reset();
    #2;
    check_eq("rst_a_X", x_a, 0);
    check_eq("rst_a_busy", busy_a, 0);
    check_eq("rst_a_q", q_a, 0);
    check_eq("rst_b_G", g_b, 0);
    #10 rst_n = 1'b1;

    step(1'b0, 1'b0, 4'd0);

    // Basic trains: 3 pulses, 2^WIDTH pulses, 2 pulses.
    run_train(4'd3, 1'b0);
    run_train(4'd0, 1'b0);
    check_eq("a_16_rises", rises_a, 16);
    run_train(4'd2, 1'b0);

    // Abort during the 2nd pulse's low gap of dut_a.
    step(1'b1, 1'b0, 4'd5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd5);
    check_eq("abort_pre_gap_X", x_a, 0);
    step(1'b0, 1'b1, 4'd5);
    check_eq("abort_X", x_a, 0);
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_q", q_a, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd5);
    run_train(4'd5, 1'b0);

    // S re-pulsed with a different N mid-train has no effect.
    run_train(4'd4, 1'b1);

    // S and A together in idle: nothing starts.
    step(1'b1, 1'b1, 4'd3);
    check_eq("sa_idle_busy", busy_a, 0);
    check_eq("sa_idle_X", x_b, 0);

    // A while dut_a is in done (ignored) and dut_b still pulsing (aborts).
    step(1'b1, 1'b0, 4'd1);
    step(1'b0, 1'b0, 4'd1);
    check_eq("t3_G", g_a, 1);
    step(1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b0, 4'd1);

    // Asynchronous reset while X is high.
    step(1'b1, 1'b0, 4'd6);
    check_eq("pre_rst_X", x_a, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_X", x_a, 0);
    check_eq("async_rst_busy", busy_b, 0);
    check_eq("async_rst_q", q_a, 0);
    check_eq("async_rst_G", g_a, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd6);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, W'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 200 && (busy_a || busy_b); i++) step(1'b0, 1'b0, 4'd0);
    check_eq("final_idle", busy_a || busy_b, 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
